jpeg_dequantizer: RTL
=====================

// Module: jpeg_dequantizer
// PURPOSE
//  Inverse of the encoder's quantizer/divider path: multiplies each quantized 8x8 DCT coefficient
//  by its quantization-table entry, producing reconstructed coefficients for the decoder IDCT.
//  Sits between the entropy/run-length decoder (upstream) and the IDCT (downstream).
//  Streaming valid/ready on both sides; raster-order coefficient index is tracked internally.
// PARAMETERS
//  COEF_W   12  signed width of quantized input coefficient
//  Q_W       8  unsigned width of a quant-table entry
//  OUT_W    16  signed width of dequantized output (saturated)
// PORTS
//  clk          in   1       clock, all logic rising-edge
//  rst_n        in   1       asynchronous active-low reset
//  qt_we        in   1       quant-table write strobe
//  qt_addr      in   6       quant-table write index, 0..63
//  qt_data      in   Q_W     quant-table write value
//  blk_restart  in   1       sync: force coefficient index to 0 (start new block)
//  in_valid     in   1       input coefficient valid
//  in_ready     out  1       block can accept input this cycle
//  in_coef      in   COEF_W  quantized coefficient (signed)
//  out_valid    out  1       output coefficient valid
//  out_ready    in   1       downstream accepts output
//  out_coef     out  OUT_W   dequantized coefficient (signed, saturated)
//  out_idx      out  6       raster index of out_coef within block
//  out_eob      out  1       high with out_valid when out_idx == 63
//  busy         out  1       any pipeline stage holds valid data
// BEHAVIOUR
//  - Reset: out_valid=0, out_coef=0, out_idx=0, out_eob=0, busy=0, index counter=0,
//    all stage valids cleared; table contents undefined after reset (not cleared).
//  - Accept on in_valid & in_ready. Pipeline S1 (table read, coef/idx registered),
//    S2 (signed multiply, COEF_W+Q_W+1 bit product), S3 (saturate, output register).
//  - Latency: accepted coefficient appears on out_* exactly 3 cycles later if no stall.
//  - Backpressure: whole pipeline advances when !S3.valid | out_ready; otherwise every stage
//    holds. in_ready = !S1.valid | advance (registered-free, combinational from out_ready).
//    Bubbles collapse: an empty stage is filled even if the stage after it holds.
//  - out_* stable while out_valid & !out_ready; out_valid never drops without a handshake.
//  - Throughput: one coefficient per cycle with out_ready held high.
//  - Index counter: increments on each accept, wraps 63->0; tag travels with data.
//  - blk_restart: counter <= 0. Same-cycle restart and accept: accepted coef gets idx 0,
//    counter <= 1. Does not flush in-flight data.
//  - Table write: a write in cycle N is seen by coefficients accepted in cycle N+1 onward;
//    same-cycle write and read of the same address returns the old value.
//  - Arithmetic: product = signed(in_coef) * {1'b0,q}; clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    q == 0 yields 0 (no special case).
//  - Reset asserted mid-block: all in-flight data discarded, next accepted coef is idx 0.
// STRUCTURE
//  - Package jpeg_dq_pkg: BLK_COEFS=64, typedef logic [5:0] coef_idx_t, default widths,
//    saturate function sat_s(product) shared with any future IDCT input clamps.
//  - Sub-module jpeg_dq_qtable: 64 x Q_W, one write port, one registered read port
//    (read-before-write), read enable tied to pipeline advance so output holds on stall.
//  - Top: index counter, stage-valid/ready control, multiply, saturate, output register.
// TESTING
//  1. Reset, table all 1, stream 64 coefs 0..63, out_ready=1 -> out_coef=0..63, out_idx=0..63,
//     first out_valid 3 cycles after first accept, out_eob only on idx 63, 64 consecutive beats.
//  2. Table entry 5 = 200, coef at idx 5 = -2047 -> out_coef = -409400 saturates to -32768;
//     coef 2047 x q 255 -> 32767.
//  3. out_ready low 5 cycles mid-block with in_valid high -> exactly 3 coefs in flight,
//     in_ready low, out_* stable; release -> no loss/duplication, indices contiguous.
//  4. qt_we addr 10 = 7 same cycle idx 10 accepted (old q=3, coef 4) -> 12; next block idx 10 -> 28.
//  5. blk_restart with simultaneous accept after 20 coefs -> that coef out_idx=0, next 1.
//  6. rst_n low mid-block with 3 in flight -> out_valid=0, busy=0 immediately (async);
//     after release first accepted coef has out_idx=0.

Source files
------------

// File: rtl/jpeg_dq_pkg.sv
// Shared types, widths and the output saturation helper for the JPEG dequantizer.
package jpeg_dq_pkg;

    localparam int unsigned COEF_W    = 12;
    localparam int unsigned Q_W       = 8;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned BLK_COEFS = 64;
    localparam int unsigned PROD_W    = COEF_W + Q_W + 1;

    typedef logic [IDX_W-1:0]         coef_idx_t;
    typedef logic signed [COEF_W-1:0] q_coef_t;
    typedef logic [Q_W-1:0]           q_entry_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [OUT_W-1:0]  dq_coef_t;

    // Coefficient plus its raster tag as it travels down the pipeline
    typedef struct packed {
        q_coef_t   coef;
        coef_idx_t idx;
    } dq_beat_t;

    localparam prod_t SAT_MAX = prod_t'((1 << (OUT_W - 1)) - 1);
    localparam prod_t SAT_MIN = prod_t'(-(1 << (OUT_W - 1)));

    // Clamp a full-width product into the signed output range
    function automatic dq_coef_t sat_s(input prod_t p);
        dq_coef_t r;
        if (p > SAT_MAX) begin
            r = dq_coef_t'(SAT_MAX);
        end else if (p < SAT_MIN) begin
            r = dq_coef_t'(SAT_MIN);
        end else begin
            r = dq_coef_t'(p);
        end
        return r;
    endfunction

endpackage

// File: rtl/jpeg_dq_qtable.sv
// 64-entry quantization table: one write port, one registered read-before-write read port.
module jpeg_dq_qtable
    import jpeg_dq_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  coef_idx_t waddr,
    input  q_entry_t  wdata,
    input  logic      rd_en,
    input  coef_idx_t raddr,
    output q_entry_t  rdata
);

    q_entry_t mem [BLK_COEFS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only moves on enable so it stays aligned with the stage it feeds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jpeg_dequantizer.sv
// Streaming JPEG dequantizer: coef * qtable[idx], saturated, 3-stage valid/ready pipeline.
module jpeg_dequantizer
    import jpeg_dq_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      qt_we,
    input  coef_idx_t qt_addr,
    input  q_entry_t  qt_data,
    input  logic      blk_restart,
    input  logic      in_valid,
    output logic      in_ready,
    input  q_coef_t   in_coef,
    output logic      out_valid,
    input  logic      out_ready,
    output dq_coef_t  out_coef,
    output coef_idx_t out_idx,
    output logic      out_eob,
    output logic      busy
);

    logic      s1_v, s2_v, s3_v;
    logic      advance, en2, accept;
    coef_idx_t cnt, tag_c;
    dq_beat_t  s1;
    q_entry_t  q;
    prod_t     prod_c, s2_prod;
    coef_idx_t s2_idx;

    // Stages advance together; an empty stage may still be filled behind a held one
    assign advance  = !s3_v || out_ready;
    assign en2      = !s2_v || advance;
    assign in_ready = !s1_v || advance;
    assign accept   = in_valid && in_ready;

    assign tag_c = blk_restart ? '0 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= tag_c + coef_idx_t'(1);
        end else if (blk_restart) begin
            cnt <= '0;
        end
    end

    jpeg_dq_qtable u_qtable (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (qt_we),
        .waddr (qt_addr),
        .wdata (qt_data),
        .rd_en (accept),
        .raddr (tag_c),
        .rdata (q)
    );

    // S1: register coefficient and tag alongside the table read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1   <= '0;
        end else begin
            if (in_ready || en2) begin
                s1_v <= accept;
            end
            if (accept) begin
                s1 <= '{coef: in_coef, idx: tag_c};
            end
        end
    end

    assign prod_c = prod_t'(s1.coef) * prod_t'(signed'({1'b0, q}));

    // S2: full-width signed product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_prod <= '0;
            s2_idx  <= '0;
        end else if (en2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_prod <= prod_c;
                s2_idx  <= s1.idx;
            end
        end
    end

    // S3: saturate into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v     <= 1'b0;
            out_coef <= '0;
            out_idx  <= '0;
            out_eob  <= 1'b0;
        end else if (advance) begin
            s3_v    <= s2_v;
            out_eob <= s2_v && (s2_idx == coef_idx_t'(BLK_COEFS - 1));
            if (s2_v) begin
                out_coef <= sat_s(s2_prod);
                out_idx  <= s2_idx;
            end
        end
    end

    assign out_valid = s3_v;
    assign busy      = s1_v || s2_v || s3_v;

endmodule
